// File: rtl/rs485_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : rs485_line_ctrl
// Purpose : N-channel half-duplex RS-485 transceiver direction control with
//           guard times, registered line pins and synchronised receive data.
//           Optional echo check: define RS485_ECHO_CHECK_EN.
// Rev     : 1.0  initial release
// ============================================================================
module rs485_line_ctrl #(
  parameter int   CH_NUM     = 22,
  parameter int   PRE_GUARD  = 4,
  parameter int   POST_GUARD = 4,
  parameter logic IDLE_D     = 1'b1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [CH_NUM-1:0] tx_req,
  input  logic [CH_NUM-1:0] tx_d,
  output logic [CH_NUM-1:0] tx_gnt,
  output logic [CH_NUM-1:0] tx_busy,
  input  logic [CH_NUM-1:0] rx_en,
  output logic [CH_NUM-1:0] rx_d,
  input  logic [CH_NUM-1:0] line_r,
  output logic [CH_NUM-1:0] line_d,
  output logic [CH_NUM-1:0] line_nre,
  output logic [CH_NUM-1:0] line_de,
  input  logic [CH_NUM-1:0] echo_clr,
  output logic [CH_NUM-1:0] echo_err
);

  localparam int c_guard_max = (PRE_GUARD > POST_GUARD) ? PRE_GUARD : POST_GUARD;
  localparam int c_cnt_w     = $clog2(c_guard_max + 1);
  localparam logic [c_cnt_w-1:0] c_pre_last  = c_cnt_w'(PRE_GUARD - 1);
  localparam logic [c_cnt_w-1:0] c_post_last = c_cnt_w'(POST_GUARD - 1);

`ifdef RS485_ECHO_CHECK_EN
  localparam logic c_nre_busy = 1'b0;
`else
  localparam logic c_nre_busy = 1'b1;
  logic unused_echo_clr;
  assign unused_echo_clr = ^echo_clr;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_POST = 2'd3
  } state_t;

  for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_ch
    state_t             state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               de_q, de_d;
    logic               d_q, d_d;
    logic               nre_q, nre_d;
    logic               gnt_q, gnt_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
        ST_IDLE: if (tx_req[ch]) state_d = ST_PRE;
        ST_PRE: begin
          if (!tx_req[ch])              state_d = ST_POST;
          else if (cnt_q == c_pre_last) state_d = ST_DATA;
          else                          cnt_d   = cnt_q + c_cnt_w'(1);
        end
        ST_DATA: if (!tx_req[ch]) state_d = ST_POST;
        ST_POST: begin
          // Re-request during the tail skips the pre-guard: the driver is still on.
          if (tx_req[ch])                state_d = ST_DATA;
          else if (cnt_q == c_post_last) state_d = ST_IDLE;
          else                           cnt_d   = cnt_q + c_cnt_w'(1);
        end
        default: state_d = ST_IDLE;
      endcase

      de_d    = (state_d != ST_IDLE);
      gnt_d   = (state_d == ST_DATA);
      d_d     = (state_q == ST_DATA) ? tx_d[ch] : IDLE_D;
      nre_d   = (state_d == ST_IDLE) ? ~rx_en[ch] : c_nre_busy;
      sync1_d = nre_q ? IDLE_D : line_r[ch];
      sync2_d = nre_q ? IDLE_D : sync1_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        de_q    <= 1'b0;
        d_q     <= IDLE_D;
        nre_q   <= 1'b1;
        gnt_q   <= 1'b0;
        sync1_q <= IDLE_D;
        sync2_q <= IDLE_D;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        de_q    <= de_d;
        d_q     <= d_d;
        nre_q   <= nre_d;
        gnt_q   <= gnt_d;
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
      end
    end

    assign tx_gnt[ch]   = gnt_q;
    assign tx_busy[ch]  = de_q;
    assign line_de[ch]  = de_q;
    assign line_d[ch]   = d_q;
    assign line_nre[ch] = nre_q;
    assign rx_d[ch]     = sync2_q;

`ifdef RS485_ECHO_CHECK_EN
    // Delay each driven data bit by the two synchroniser stages before comparing.
    logic       vld_q, vld_d;
    logic [1:0] dpipe_q, dpipe_d;
    logic [1:0] vpipe_q, vpipe_d;
    logic       err_q, err_d;

    always_comb begin
      vld_d   = (state_q == ST_DATA);
      dpipe_d = {dpipe_q[0], d_q};
      vpipe_d = {vpipe_q[0], vld_q};
      err_d   = (err_q & ~echo_clr[ch]) | (vpipe_q[1] & (dpipe_q[1] != sync2_q));
    end

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        vld_q   <= 1'b0;
        dpipe_q <= {2{IDLE_D}};
        vpipe_q <= 2'b00;
        err_q   <= 1'b0;
      end else begin
        vld_q   <= vld_d;
        dpipe_q <= dpipe_d;
        vpipe_q <= vpipe_d;
        err_q   <= err_d;
      end
    end

    assign echo_err[ch] = err_q;
`else
    assign echo_err[ch] = 1'b0;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_rs485_line_ctrl.sv
`default_nettype none
// Testbench for rs485_line_ctrl: 4 channels, 4-cycle guards, idle level 1.
module tb_rs485_line_ctrl;

  localparam int N = 4;
`ifdef RS485_ECHO_CHECK_EN
  localparam logic NRE_BUSY = 1'b0;
`else
  localparam logic NRE_BUSY = 1'b1;
`endif

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic [N-1:0] tx_req = '0, tx_d = '0, rx_en = '0, line_r = '1, echo_clr = '0;
  logic [N-1:0] tx_gnt, tx_busy, rx_d, line_d, line_nre, line_de, echo_err;

  rs485_line_ctrl #(.CH_NUM(N), .PRE_GUARD(4), .POST_GUARD(4), .IDLE_D(1'b1)) dut (
    .clk(clk), .n_rst(n_rst),
    .tx_req(tx_req), .tx_d(tx_d), .tx_gnt(tx_gnt), .tx_busy(tx_busy),
    .rx_en(rx_en), .rx_d(rx_d), .line_r(line_r), .line_d(line_d),
    .line_nre(line_nre), .line_de(line_de),
    .echo_clr(echo_clr), .echo_err(echo_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [N-1:0] gnt_acc;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] txd;
    logic [N-1:0] de;
    logic [N-1:0] d;
    logic [N-1:0] gnt;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    gnt_acc |= tx_gnt;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " de"},   line_de,  4'b0000);
    chk({nm, " d"},    line_d,   4'b1111);
    chk({nm, " nre"},  line_nre, 4'b1111);
    chk({nm, " rx_d"}, rx_d,     4'b1111);
    chk({nm, " busy"}, tx_busy,  4'b0000);
    chk({nm, " gnt"},  tx_gnt,   4'b0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Channel 0 frame: request held for cycles 0..11, data bits during grant.
    vecs[0]  = '{4'b0001, 4'b0000, 4'b0000, 4'b1111, 4'b0000};
    vecs[1]  = '{4'b0001, 4'b0000, 4'b0001, 4'b1111, 4'b0000};
    vecs[2]  = '{4'b0001, 4'b0000, 4'b0001, 4'b1111, 4'b0000};
    vecs[3]  = '{4'b0001, 4'b0000, 4'b0001, 4'b1111, 4'b0000};
    vecs[4]  = '{4'b0001, 4'b0000, 4'b0001, 4'b1111, 4'b0000};
    vecs[5]  = '{4'b0001, 4'b0001, 4'b0001, 4'b1111, 4'b0001};
    vecs[6]  = '{4'b0001, 4'b0000, 4'b0001, 4'b1111, 4'b0001};
    vecs[7]  = '{4'b0001, 4'b0001, 4'b0001, 4'b1110, 4'b0001};
    vecs[8]  = '{4'b0001, 4'b0001, 4'b0001, 4'b1111, 4'b0001};
    vecs[9]  = '{4'b0001, 4'b0000, 4'b0001, 4'b1111, 4'b0001};
    vecs[10] = '{4'b0001, 4'b0000, 4'b0001, 4'b1110, 4'b0001};
    vecs[11] = '{4'b0001, 4'b0001, 4'b0001, 4'b1110, 4'b0001};
    vecs[12] = '{4'b0000, 4'b0000, 4'b0001, 4'b1111, 4'b0001};
    vecs[13] = '{4'b0000, 4'b0000, 4'b0001, 4'b1110, 4'b0000};
    vecs[14] = '{4'b0000, 4'b0000, 4'b0001, 4'b1111, 4'b0000};
    vecs[15] = '{4'b0000, 4'b0000, 4'b0001, 4'b1111, 4'b0000};
    vecs[16] = '{4'b0000, 4'b0000, 4'b0001, 4'b1111, 4'b0000};
    vecs[17] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000};
    vecs[18] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000};

    // Reset state, held and just after release.
    step(); step();
    chk_idle("reset");
    chk("reset echo_err", echo_err, 4'b0000);
    n_rst = 1'b1;
    step();
    chk_idle("release");

    // Table-driven frame on channel 0.
    cyc = 0;
    for (int k = 0; k < 19; k++) begin
      chk($sformatf("vec%0d de", k),   line_de, vecs[k].de);
      chk($sformatf("vec%0d busy", k), tx_busy, vecs[k].de);
      chk($sformatf("vec%0d d", k),    line_d,  vecs[k].d);
      chk($sformatf("vec%0d gnt", k),  tx_gnt,  vecs[k].gnt);
      chk($sformatf("vec%0d nre", k),  line_nre,
          {3'b111, (vecs[k].de[0] ? NRE_BUSY : 1'b1)});
      chk($sformatf("vec%0d rx_d", k), rx_d,    4'b1111);
      tx_req = vecs[k].req;
      tx_d   = vecs[k].txd;
      step();
    end

    // Abort during pre-guard on channel 1: full post-guard, never granted.
    cyc = 0; gnt_acc = '0;
    tx_req = 4'b0010;
    run_to(1); chk("abort de@1", line_de, 4'b0010);
    run_to(3); tx_req = 4'b0000;
    run_to(7); chk("abort de@7", line_de, 4'b0010);
    run_to(8); chk("abort de@8", line_de, 4'b0000);
    chk("abort no gnt", gnt_acc, 4'b0000);

    // Re-request during post-guard returns to DATA without a new pre-guard.
    run_to(10);
    cyc = 0;
    tx_req = 4'b0010;
    run_to(5); chk("rereq gnt@5", tx_gnt, 4'b0010);
    run_to(6); tx_req = 4'b0000;
    run_to(7); chk("rereq gnt@7", tx_gnt, 4'b0000);
    chk("rereq de@7", line_de, 4'b0010);
    run_to(8); tx_req = 4'b0010;
    run_to(9); chk("rereq gnt@9", tx_gnt, 4'b0010);
    run_to(10); tx_req = 4'b0000;
    run_to(14); chk("rereq de@14", line_de, 4'b0010);
    run_to(15); chk("rereq de@15", line_de, 4'b0000);

    // Receive path on channel 2.
    cyc = 0;
    rx_en = 4'b0100;
    run_to(1); chk("rx nre@1", line_nre, 4'b1011);
    run_to(2); line_r = 4'b1011;
    run_to(3); chk("rx d@3", rx_d, 4'b1111);
    run_to(4); chk("rx d@4", rx_d, 4'b1011);
    line_r = 4'b1111;
    run_to(5); chk("rx d@5", rx_d, 4'b1011);
    run_to(6); chk("rx d@6", rx_d, 4'b1111);
    line_r = 4'b1011;
    run_to(8); chk("rx d@8", rx_d, 4'b1011);
    rx_en = 4'b0000;
    run_to(9); chk("rx nre@9", line_nre, 4'b1111);
    run_to(10); chk("rx d@10", rx_d, 4'b1111);
    run_to(12); chk("rx d@12", rx_d, 4'b1111);
    line_r = 4'b1111;

`ifdef RS485_ECHO_CHECK_EN
    // Echo mismatch on channel 3 while driving 1s.
    run_to(14);
    cyc = 0;
    tx_req = 4'b1000; tx_d = 4'b1000;
    run_to(2);  chk("echo nre@2", line_nre, 4'b0111);
    run_to(8);  chk("echo err@8", {3'b000, echo_err[3]}, 4'b0000);
    line_r = 4'b0111;
    run_to(9);  line_r = 4'b1111;
    run_to(10); chk("echo err@10", {3'b000, echo_err[3]}, 4'b0000);
    chk("echo rx_d@10", {3'b000, rx_d[3]}, 4'b0000);
    run_to(11); chk("echo err@11", {3'b000, echo_err[3]}, 4'b0001);
    run_to(14); chk("echo err sticky", {3'b000, echo_err[3]}, 4'b0001);
    echo_clr = 4'b1000;
    run_to(15); chk("echo clr", {3'b000, echo_err[3]}, 4'b0000);
    echo_clr = 4'b0000;
    tx_req = 4'b0000; tx_d = 4'b0000;
    run_to(25);
`endif

    // Asynchronous reset in the middle of a frame.
    cyc = 0;
    tx_req = 4'b0001; tx_d = 4'b0000;
    run_to(7);
    chk("midrst gnt before", tx_gnt, 4'b0001);
    chk("midrst d before", line_d, 4'b1110);
    n_rst = 1'b0;
    #2;
    chk_idle("midrst");
    chk("midrst echo_err", echo_err, 4'b0000);
    tx_req = 4'b0000;
    step();
    n_rst = 1'b1;
    step(); step();
    chk_idle("post-rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
